dff_bank_arbiter: RTL and testbench

Round-robin arbiter and write sequencer that shares one WIDTH-bit D flip-flop storage register among N requesters. Each requester raises a request with its data. The block grants one requester at a time, loads that requester's data into the shared register, and acknowledges the write. It sits between the lab's requester logic and the DFlipFlop-based storage, replacing direct `d` drive with an arbitrated, handshaked write path.

---
 rtl/dff_bank_arbiter.sv | 152 +++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N requesters; burst lock under `DFF_ARB_LOCK_EN`.
// Grant 1 cycle after req, write+ack the cycle after; requesters are held off by holding req until ack.
module dff_bank_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic [N-1:0]         req,
   input  logic [N*WIDTH-1:0]   wdata,
   input  logic [N-1:0]         lock,
   output logic [N-1:0]         gnt,
   output logic [N-1:0]         ack,
   output logic [WIDTH-1:0]     q,
   output logic                 q_valid,
   output logic [2:0]           owner,
   output logic [7:0]           wr_count
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N-1:0]     r_gnt;
   logic [N-1:0]     r_ack;
   logic [WIDTH-1:0] r_q;
   logic             r_q_valid;
   logic [2:0]       r_owner;
   logic [7:0]       r_wr_count;
   logic [2:0]       r_ptr;
   logic [2:0]       r_win;

   logic [2:0]       w_rr_idx;
   logic             w_req_win;
   logic             w_burst;
   logic [WIDTH-1:0] w_wsel;
   logic [N-1:0]     w_gnt_nxt;
   logic [N-1:0]     w_ack_nxt;
   logic [2:0]       w_ptr_nxt;
   logic [2:0]       w_win_nxt;
   logic             w_load;

   // Scan from farthest to nearest so the first requester after p overrides.
   function automatic logic [2:0] rr_pick(input logic [N-1:0] r, input logic [2:0] p);
      logic [2:0]   idx;
      logic [N-1:0] m;
      rr_pick = '0;
      for (int k = N; k >= 1; k--) begin
         idx = 3'((32'(p) + 32'(k)) % 32'(N));
         m   = N'(1) << idx;
         if (|(r & m)) rr_pick = idx;
      end
   endfunction

   assign w_rr_idx  = rr_pick(req, r_ptr);
   assign w_req_win = |(req & r_gnt);

`ifdef DFF_ARB_LOCK_EN
   assign w_burst = |(lock & r_gnt) & w_req_win;
`else
   logic w_lock_unused;
   assign w_lock_unused = |lock;
   assign w_burst       = 1'b0;
`endif

   always_comb begin
      w_wsel = '0;
      for (int i = 0; i < N; i++) begin
         if (r_gnt[i]) w_wsel = wdata[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (|req) w_state_nxt = S_GRANT;
         S_GRANT: w_state_nxt = w_req_win ? S_ACK : S_IDLE;
         S_ACK:   w_state_nxt = w_burst ? S_GRANT : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_gnt_nxt = r_gnt;
      w_ack_nxt = '0;
      w_ptr_nxt = r_ptr;
      w_win_nxt = r_win;
      w_load    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_gnt_nxt = '0;
            if (|req) begin
               w_gnt_nxt = N'(1) << w_rr_idx;
               w_win_nxt = w_rr_idx;
            end
         end
         S_GRANT: begin
            if (w_req_win) begin
               w_load    = 1'b1;
               w_ack_nxt = r_gnt;
            end else begin
               w_gnt_nxt = '0;
            end
         end
         S_ACK: begin
            // Pointer moves only once the burst (if any) ends, so aborts never shift fairness.
            if (!w_burst) begin
               w_gnt_nxt = '0;
               w_ptr_nxt = r_win;
            end
         end
         default: w_gnt_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_gnt      <= '0;
         r_ack      <= '0;
         r_q        <= '0;
         r_q_valid  <= 1'b0;
         r_owner    <= '0;
         r_wr_count <= '0;
         r_ptr      <= 3'(N-1);
         r_win      <= '0;
      end else begin
         r_gnt <= w_gnt_nxt;
         r_ack <= w_ack_nxt;
         r_ptr <= w_ptr_nxt;
         r_win <= w_win_nxt;
         if (w_load) begin
            r_q        <= w_wsel;
            r_q_valid  <= 1'b1;
            r_owner    <= r_win;
            r_wr_count <= r_wr_count + 8'd1;
         end
      end
   end

   assign gnt      = r_gnt;
   assign ack      = r_ack;
   assign q        = r_q;
   assign q_valid  = r_q_valid;
   assign owner    = r_owner;
   assign wr_count = r_wr_count;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed table-driven bench for dff_bank_arbiter (N=4, WIDTH=8), plus reset, wrap and lock sequences.
module tb_dff_bank_arbiter;

   logic        clk = 1'b0;
   logic        nreset;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  lock;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [7:0]  q;
   logic        q_valid;
   logic [2:0]  owner;
   logic [7:0]  wr_count;

   int n_cmp = 0;
   int n_err = 0;

   dff_bank_arbiter #(.N(4), .WIDTH(8)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .req      (req),
      .wdata    (wdata),
      .lock     (lock),
      .gnt      (gnt),
      .ack      (ack),
      .q        (q),
      .q_valid  (q_valid),
      .owner    (owner),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic [31:0] wd;
      logic [3:0]  gnt;
      logic [3:0]  ack;
      logic [7:0]  q;
      logic        qv;
      logic [2:0]  own;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic rst_n, input logic [3:0] rq, input logic [31:0] wd,
                               input logic [3:0] eg, input logic [3:0] ea, input logic [7:0] eq,
                               input logic eqv, input logic [2:0] eo, input logic [7:0] ec);
      vec_t v;
      v.rst_n = rst_n; v.req = rq; v.wd = wd;
      v.gnt = eg; v.ack = ea; v.q = eq; v.qv = eqv; v.own = eo; v.cnt = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [3:0] eg, input logic [3:0] ea,
                        input logic [7:0] eq, input logic eqv, input logic [2:0] eo,
                        input logic [7:0] ec);
      n_cmp++;
      if (gnt !== eg || ack !== ea || q !== eq || q_valid !== eqv || owner !== eo || wr_count !== ec) begin
         n_err++;
         $display("FAIL %s: got gnt=%h ack=%h q=%h qv=%b owner=%0d cnt=%0d, want gnt=%h ack=%h q=%h qv=%b owner=%0d cnt=%0d",
                  name, gnt, ack, q, q_valid, owner, wr_count, eg, ea, eq, eqv, eo, ec);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      nreset = 1'b1;
      req    = '0;
      wdata  = '0;
      lock   = '0;
      #2;
      nreset = 1'b0;
      #1;
      check("reset_state", 4'h0, 4'h0, 8'h00, 1'b0, 3'd0, 8'd0);

      // single write, then req=1111 from reset (order 0,1,2,3,0), then abort by requester 2
      tv.push_back(mk(1'b0, 4'b0000, 32'h0,        4'h0, 4'h0, 8'h00, 1'b0, 3'd0, 8'd0));
      tv.push_back(mk(1'b1, 4'b0001, 32'h000000A5, 4'h1, 4'h0, 8'h00, 1'b0, 3'd0, 8'd0));
      tv.push_back(mk(1'b1, 4'b0001, 32'h000000A5, 4'h1, 4'h1, 8'hA5, 1'b1, 3'd0, 8'd1));
      tv.push_back(mk(1'b1, 4'b0000, 32'h000000A5, 4'h0, 4'h0, 8'hA5, 1'b1, 3'd0, 8'd1));
      tv.push_back(mk(1'b0, 4'b0000, 32'h0,        4'h0, 4'h0, 8'h00, 1'b0, 3'd0, 8'd0));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h1, 4'h0, 8'h00, 1'b0, 3'd0, 8'd0));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h1, 4'h1, 8'h11, 1'b1, 3'd0, 8'd1));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h0, 4'h0, 8'h11, 1'b1, 3'd0, 8'd1));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h2, 4'h0, 8'h11, 1'b1, 3'd0, 8'd1));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h2, 4'h2, 8'h22, 1'b1, 3'd1, 8'd2));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h0, 4'h0, 8'h22, 1'b1, 3'd1, 8'd2));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h4, 4'h0, 8'h22, 1'b1, 3'd1, 8'd2));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h4, 4'h4, 8'h33, 1'b1, 3'd2, 8'd3));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h0, 4'h0, 8'h33, 1'b1, 3'd2, 8'd3));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h8, 4'h0, 8'h33, 1'b1, 3'd2, 8'd3));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h8, 4'h8, 8'h44, 1'b1, 3'd3, 8'd4));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h0, 4'h0, 8'h44, 1'b1, 3'd3, 8'd4));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h1, 4'h0, 8'h44, 1'b1, 3'd3, 8'd4));
      tv.push_back(mk(1'b1, 4'b1111, 32'h44332211, 4'h1, 4'h1, 8'h11, 1'b1, 3'd0, 8'd5));
      tv.push_back(mk(1'b1, 4'b0000, 32'h44332211, 4'h0, 4'h0, 8'h11, 1'b1, 3'd0, 8'd5));
      tv.push_back(mk(1'b1, 4'b0100, 32'h44332211, 4'h4, 4'h0, 8'h11, 1'b1, 3'd0, 8'd5));
      tv.push_back(mk(1'b1, 4'b0000, 32'h44332211, 4'h0, 4'h0, 8'h11, 1'b1, 3'd0, 8'd5));
      tv.push_back(mk(1'b1, 4'b0110, 32'h44332211, 4'h2, 4'h0, 8'h11, 1'b1, 3'd0, 8'd5));
      tv.push_back(mk(1'b1, 4'b0110, 32'h44332211, 4'h2, 4'h2, 8'h22, 1'b1, 3'd1, 8'd6));
      tv.push_back(mk(1'b1, 4'b0000, 32'h44332211, 4'h0, 4'h0, 8'h22, 1'b1, 3'd1, 8'd6));

      for (int i = 0; i < tv.size(); i++) begin
         nreset = tv[i].rst_n;
         req    = tv[i].req;
         wdata  = tv[i].wd;
         tick();
         check($sformatf("vec%0d", i), tv[i].gnt, tv[i].ack, tv[i].q, tv[i].qv, tv[i].own, tv[i].cnt);
      end

      // reset asynchronously while requester 0 is in GRANT writing 0x3C
      req = 4'b0001; wdata = 32'h4433223C;
      tick();
      check("pre_rst_grant", 4'h1, 4'h0, 8'h22, 1'b1, 3'd1, 8'd6);
      #2 nreset = 1'b0;
      #1 check("async_rst", 4'h0, 4'h0, 8'h00, 1'b0, 3'd0, 8'd0);
      tick();
      check("rst_held", 4'h0, 4'h0, 8'h00, 1'b0, 3'd0, 8'd0);
      nreset = 1'b1; req = 4'b1000;
      tick(); check("post_rst_gnt3", 4'h8, 4'h0, 8'h00, 1'b0, 3'd0, 8'd0);
      tick(); check("post_rst_wr3",  4'h8, 4'h8, 8'h44, 1'b1, 3'd3, 8'd1);
      req = 4'b1001;
      tick(); check("post_rst_ack3", 4'h0, 4'h0, 8'h44, 1'b1, 3'd3, 8'd1);
      tick(); check("rr_gnt0",       4'h1, 4'h0, 8'h44, 1'b1, 3'd3, 8'd1);
      tick(); check("rr_wr0",        4'h1, 4'h1, 8'h3C, 1'b1, 3'd0, 8'd2);
      req = 4'b0000;
      tick(); check("rr_ack0",       4'h0, 4'h0, 8'h3C, 1'b1, 3'd0, 8'd2);

      // 256 back-to-back writes from requester 1: counter wraps, q_valid stays set
      @(posedge clk); #1 nreset = 1'b0;
      #2 nreset = 1'b1;
      req = 4'b0010; wdata = 32'h00005A00;
      tick();
      check("wrap_first_gnt", 4'h2, 4'h0, 8'h00, 1'b0, 3'd0, 8'd0);
      for (int i = 1; i <= 256; i++) begin
         tick();
         check($sformatf("wrap_wr%0d", i), 4'h2, 4'h2, 8'h5A, 1'b1, 3'd1, 8'(i));
         tick();
         tick();
      end
      req = 4'b0000;
      tick();
      check("wrap_abort_idle", 4'h0, 4'h0, 8'h5A, 1'b1, 3'd1, 8'd0);

`ifdef DFF_ARB_LOCK_EN
      @(posedge clk); #1 nreset = 1'b0;
      #2 nreset = 1'b1;
      req = 4'b0001; wdata = 32'h00007711;
      tick(); tick();
      req = 4'b0000;
      tick();
      check("lock_setup", 4'h0, 4'h0, 8'h11, 1'b1, 3'd0, 8'd1);
      lock = 4'b0010; req = 4'b0011;
      tick();
      check("lock_gnt1", 4'h2, 4'h0, 8'h11, 1'b1, 3'd0, 8'd1);
      for (int w = 1; w <= 4; w++) begin
         tick();
         check($sformatf("lock_wr%0d", w), 4'h2, 4'h2, 8'h77, 1'b1, 3'd1, 8'(w + 1));
         if (w == 4) lock = 4'b0000;
         tick();
         check($sformatf("lock_ack%0d", w), (w < 4) ? 4'h2 : 4'h0, 4'h0, 8'h77, 1'b1, 3'd1, 8'(w + 1));
      end
      tick();
      check("lock_release_gnt0", 4'h1, 4'h0, 8'h77, 1'b1, 3'd1, 8'd5);
      req = 4'b0000;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
